// File: rtl/hazard_ctrl.sv
// Hazard control for a 5-stage pipeline: operand forwarding, load-use and
// branch stalls/flushes, and a data-memory wait FSM with a sticky timeout error.
module hazard_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RA1E,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             BranchTakenE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCount,
  output logic [1:0]       mem_state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } mem_state_e;

  localparam logic [3:0]       TIMEOUT_C = 4'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  mem_state_e       state_q, state_d;
  logic [3:0]       wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic ldr_stall;
  logic pc_pend;
  logic mem_stall;
  logic any_stall;

  // Memory-stage result is younger than writeback, so it wins.
  assign ForwardAE = (RegWriteM && (RA1E == WA3M)) ? 2'b10 :
                     (RegWriteW && (RA1E == WA3W)) ? 2'b01 : 2'b00;
  assign ForwardBE = (RegWriteM && (RA2E == WA3M)) ? 2'b10 :
                     (RegWriteW && (RA2E == WA3W)) ? 2'b01 : 2'b00;

  assign ldr_stall = ((RA1D == WA3E) || (RA2D == WA3E)) && MemtoRegE;
  assign pc_pend   = PCSrcD || PCSrcE || PCSrcM;
  assign mem_stall = ((state_q == IDLE) && MemReqM && !MemReadyM) ||
                     ((state_q == WAIT) && !MemReadyM) ||
                     (state_q == ERR);

  // A memory stall freezes everything; flushes wait until it lifts.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = ldr_stall || pc_pend;
      StallD = ldr_stall;
      FlushE = ldr_stall || BranchTakenE;
      FlushD = pc_pend || BranchTakenE;
    end
  end

  assign any_stall = StallF || StallD || StallE || StallM;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (MemReqM && !MemReadyM) begin
          state_d    = WAIT;
          wait_cnt_d = 4'd1;
        end
      end
      WAIT: begin
        if (MemReadyM) begin
          state_d    = IDLE;
          wait_cnt_d = 4'd0;
        end else if (wait_cnt_q == TIMEOUT_C) begin
          state_d = ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      ERR: state_d = ERR;
      default: begin
        state_d    = IDLE;
        wait_cnt_d = 4'd0;
      end
    endcase
    mem_err_d   = (state_d == ERR);
    stall_cnt_d = stall_cnt_q;
    if (any_stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= 4'd0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign MemErr        = mem_err_q;
  assign StallCount    = stall_cnt_q;
  assign mem_state_dbg = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: per-cycle expected output vectors are queued when
// inputs are driven and popped/compared mid-cycle.
module tb_hazard_ctrl;
  localparam int TMO = 4;
  localparam int CW  = 4;
  localparam int W   = 18;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic RegWriteM, RegWriteW, MemtoRegE, PCSrcD, PCSrcE, PCSrcM;
  logic BranchTakenE, MemReqM, MemReadyM;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [CW-1:0] StallCount;
  logic [1:0] mem_state_dbg;

  logic [W-1:0] obs;
  logic [W-1:0] e;
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int sc = 0;

  // obs layout: fa[17:16] fb[15:14] stall FDEM[13:10] flush DEW[9:7] err[6] cnt[5:2] st[1:0]
  assign obs = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                FlushD, FlushE, FlushW, MemErr, StallCount, mem_state_dbg};

  always #5 clk = ~clk;

  hazard_ctrl #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM),
    .BranchTakenE(BranchTakenE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemErr(MemErr), .StallCount(StallCount), .mem_state_dbg(mem_state_dbg)
  );

  function automatic logic [W-1:0] mk(input logic [1:0] fa, input logic [1:0] fb,
                                      input logic [3:0] stl, input logic [2:0] fl,
                                      input logic err, input logic [1:0] st);
    return {fa, fb, stl, fl, err, 4'(sc), st};
  endfunction

  function automatic logic [1:0] fwd(input logic [3:0] ra, input logic [3:0] wm,
                                     input logic rwm, input logic [3:0] ww, input logic rww);
    if (rwm && (ra == wm)) return 2'b10;
    if (rww && (ra == ww)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic idle();
    RA1D = 0; RA2D = 0; RA1E = 0; RA2E = 0; WA3E = 0; WA3M = 0; WA3W = 0;
    RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0;
    PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; BranchTakenE = 0;
    MemReqM = 0; MemReadyM = 0;
  endtask

  task automatic test_reset();
    for (int r = 0; r < 4; r++) begin
      @(posedge clk); #1;
      idle();
      case (r)
        0: exp_q.push_back(mk(2'b00, 2'b00, 4'h0, 3'b000, 1'b0, S_IDLE));
        1: begin
          MemReqM = 1;
          exp_q.push_back(mk(2'b00, 2'b00, 4'hF, 3'b001, 1'b0, S_IDLE));
        end
        2: begin
          RA1E = 2; WA3M = 2; RegWriteM = 1;
          exp_q.push_back(mk(2'b10, 2'b00, 4'h0, 3'b000, 1'b0, S_IDLE));
        end
        default: begin
          reset = 1;
          exp_q.push_back(mk(2'b00, 2'b00, 4'h0, 3'b000, 1'b0, S_IDLE));
        end
      endcase
      #2;
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL reset row%0d: got=%h want=%h", r, obs, e);
      end
      if (reset && e[13:10] != 4'h0) sc = (sc == 15) ? 15 : sc + 1;
    end
  endtask

  task automatic test_mem_wait();
    for (int r = 0; r < 7; r++) begin
      @(posedge clk); #1;
      idle();
      case (r)
        0: begin MemReqM = 1; exp_q.push_back(mk(2'b00, 2'b00, 4'hF, 3'b001, 1'b0, S_IDLE)); end
        1, 2: begin MemReqM = 1; exp_q.push_back(mk(2'b00, 2'b00, 4'hF, 3'b001, 1'b0, S_WAIT)); end
        3: begin
          MemReqM = 1; MemReadyM = 1;
          exp_q.push_back(mk(2'b00, 2'b00, 4'h0, 3'b000, 1'b0, S_WAIT));
        end
        5: begin
          MemReqM = 1; MemReadyM = 1;
          exp_q.push_back(mk(2'b00, 2'b00, 4'h0, 3'b000, 1'b0, S_IDLE));
        end
        default: exp_q.push_back(mk(2'b00, 2'b00, 4'h0, 3'b000, 1'b0, S_IDLE));
      endcase
      #2;
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL mem_wait row%0d: got=%h want=%h", r, obs, e);
      end
      if (reset && e[13:10] != 4'h0) sc = (sc == 15) ? 15 : sc + 1;
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 6; r++) begin
      @(posedge clk); #1;
      idle();
      case (r)
        0, 2: begin MemReqM = 1; exp_q.push_back(mk(2'b00, 2'b00, 4'hF, 3'b001, 1'b0, S_IDLE)); end
        1, 4: begin
          MemReqM = 1; MemReadyM = 1;
          exp_q.push_back(mk(2'b00, 2'b00, 4'h0, 3'b000, 1'b0, S_WAIT));
        end
        3: begin MemReqM = 1; exp_q.push_back(mk(2'b00, 2'b00, 4'hF, 3'b001, 1'b0, S_WAIT)); end
        default: exp_q.push_back(mk(2'b00, 2'b00, 4'h0, 3'b000, 1'b0, S_IDLE));
      endcase
      #2;
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL back_to_back row%0d: got=%h want=%h", r, obs, e);
      end
      if (reset && e[13:10] != 4'h0) sc = (sc == 15) ? 15 : sc + 1;
    end
  endtask

  task automatic test_forwarding();
    for (int r = 0; r < 25; r++) begin
      @(posedge clk); #1;
      idle();
      case (r)
        0: begin
          RA1E = 3; WA3M = 3; RegWriteM = 1; WA3W = 3; RegWriteW = 1;
          exp_q.push_back(mk(2'b10, 2'b00, 4'h0, 3'b000, 1'b0, S_IDLE));
        end
        1: begin
          RA1E = 3; WA3M = 3; RegWriteM = 0; WA3W = 3; RegWriteW = 1;
          exp_q.push_back(mk(2'b01, 2'b00, 4'h0, 3'b000, 1'b0, S_IDLE));
        end
        2: begin
          RA1E = 7; RA2E = 7; WA3M = 7; RegWriteM = 1; WA3W = 7;
          exp_q.push_back(mk(2'b10, 2'b10, 4'h0, 3'b000, 1'b0, S_IDLE));
        end
        3: begin
          RA2E = 9; WA3W = 9; RegWriteW = 1; RegWriteM = 1;
          exp_q.push_back(mk(2'b10, 2'b01, 4'h0, 3'b000, 1'b0, S_IDLE));
        end
        24: exp_q.push_back(mk(2'b00, 2'b00, 4'h0, 3'b000, 1'b0, S_IDLE));
        default: begin
          RA1E = 4'($urandom_range(0, 3)); RA2E = 4'($urandom_range(0, 3));
          WA3M = 4'($urandom_range(0, 3)); WA3W = 4'($urandom_range(0, 3));
          RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
          exp_q.push_back(mk(fwd(RA1E, WA3M, RegWriteM, WA3W, RegWriteW),
                             fwd(RA2E, WA3M, RegWriteM, WA3W, RegWriteW),
                             4'h0, 3'b000, 1'b0, S_IDLE));
        end
      endcase
      #2;
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL forwarding row%0d: got=%h want=%h", r, obs, e);
      end
      if (reset && e[13:10] != 4'h0) sc = (sc == 15) ? 15 : sc + 1;
    end
  endtask

  task automatic test_load_use();
    for (int r = 0; r < 7; r++) begin
      @(posedge clk); #1;
      idle();
      case (r)
        0: begin
          MemtoRegE = 1; WA3E = 5; RA2D = 5;
          exp_q.push_back(mk(2'b00, 2'b00, 4'b1100, 3'b010, 1'b0, S_IDLE));
        end
        2: begin
          MemtoRegE = 1; WA3E = 5; RA1D = 5; RA2D = 6;
          exp_q.push_back(mk(2'b00, 2'b00, 4'b1100, 3'b010, 1'b0, S_IDLE));
        end
        3: begin
          MemtoRegE = 1; WA3E = 5; RA1D = 4; RA2D = 6;
          exp_q.push_back(mk(2'b00, 2'b00, 4'h0, 3'b000, 1'b0, S_IDLE));
        end
        4: begin
          WA3E = 5; RA1D = 5;
          exp_q.push_back(mk(2'b00, 2'b00, 4'h0, 3'b000, 1'b0, S_IDLE));
        end
        5: begin
          MemtoRegE = 1; WA3E = 2; RA1D = 2; BranchTakenE = 1;
          exp_q.push_back(mk(2'b00, 2'b00, 4'b1100, 3'b110, 1'b0, S_IDLE));
        end
        default: exp_q.push_back(mk(2'b00, 2'b00, 4'h0, 3'b000, 1'b0, S_IDLE));
      endcase
      #2;
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL load_use row%0d: got=%h want=%h", r, obs, e);
      end
      if (reset && e[13:10] != 4'h0) sc = (sc == 15) ? 15 : sc + 1;
    end
  endtask

  task automatic test_branch();
    for (int r = 0; r < 4; r++) begin
      @(posedge clk); #1;
      idle();
      case (r)
        0: begin PCSrcD = 1; exp_q.push_back(mk(2'b00, 2'b00, 4'b1000, 3'b100, 1'b0, S_IDLE)); end
        1: begin
          PCSrcE = 1; BranchTakenE = 1;
          exp_q.push_back(mk(2'b00, 2'b00, 4'b1000, 3'b110, 1'b0, S_IDLE));
        end
        2: begin PCSrcM = 1; exp_q.push_back(mk(2'b00, 2'b00, 4'b1000, 3'b100, 1'b0, S_IDLE)); end
        default: exp_q.push_back(mk(2'b00, 2'b00, 4'h0, 3'b000, 1'b0, S_IDLE));
      endcase
      #2;
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL branch row%0d: got=%h want=%h", r, obs, e);
      end
      if (reset && e[13:10] != 4'h0) sc = (sc == 15) ? 15 : sc + 1;
    end
  endtask

  task automatic test_branch_during_wait();
    for (int r = 0; r < 5; r++) begin
      @(posedge clk); #1;
      idle();
      if (r < 4) begin
        MemReqM = 1; PCSrcE = 1; BranchTakenE = 1;
      end
      case (r)
        0: exp_q.push_back(mk(2'b00, 2'b00, 4'hF, 3'b001, 1'b0, S_IDLE));
        1, 2: exp_q.push_back(mk(2'b00, 2'b00, 4'hF, 3'b001, 1'b0, S_WAIT));
        3: begin
          MemReadyM = 1;
          exp_q.push_back(mk(2'b00, 2'b00, 4'b1000, 3'b110, 1'b0, S_WAIT));
        end
        default: exp_q.push_back(mk(2'b00, 2'b00, 4'h0, 3'b000, 1'b0, S_IDLE));
      endcase
      #2;
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL branch_in_wait row%0d: got=%h want=%h", r, obs, e);
      end
      if (reset && e[13:10] != 4'h0) sc = (sc == 15) ? 15 : sc + 1;
    end
  endtask

  // Runs into ERR, holds long enough to saturate the counter, then resets mid-ERR.
  task automatic test_timeout();
    for (int r = 0; r < 23; r++) begin
      @(posedge clk); #1;
      idle();
      if (r < 20) begin
        MemReqM = (r < 8) ? 1'b1 : 1'b0;
        exp_q.push_back(mk(2'b00, 2'b00, 4'hF, 3'b001, (r >= 5),
                           (r == 0) ? S_IDLE : (r < 5) ? S_WAIT : S_ERR));
      end else if (r == 20) begin
        reset = 0;
        sc = 0;
        exp_q.push_back(mk(2'b00, 2'b00, 4'h0, 3'b000, 1'b0, S_IDLE));
      end else if (r == 21) begin
        MemReqM = 1;
        exp_q.push_back(mk(2'b00, 2'b00, 4'hF, 3'b001, 1'b0, S_IDLE));
      end else begin
        reset = 1;
        exp_q.push_back(mk(2'b00, 2'b00, 4'h0, 3'b000, 1'b0, S_IDLE));
      end
      #2;
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL timeout row%0d: got=%h want=%h", r, obs, e);
      end
      if (reset && e[13:10] != 4'h0) sc = (sc == 15) ? 15 : sc + 1;
    end
  endtask

  initial begin
    idle();
    reset = 0;
    test_reset();
    test_mem_wait();
    test_back_to_back();
    test_forwarding();
    test_load_use();
    test_branch();
    test_branch_during_wait();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
